// File: rtl/access_pkg.sv
// Shared state encoding, timer width and default hold times for the door
// access sequencer.
package access_pkg;

  localparam int TIMER_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_GRANT   = 3'd3,
    ST_DENY    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  // A 50M-cycle wait does not fit the 24-bit shared timer, so the default clamps to full scale.
  localparam logic [TIMER_W-1:0] DEF_TIMEOUT_CYCLES = 24'hFF_FFFF;
  localparam logic [TIMER_W-1:0] DEF_UNLOCK_CYCLES  = 24'd10_000_000;
  localparam logic [TIMER_W-1:0] DEF_DENY_CYCLES    = 24'd5_000_000;
  localparam logic [TIMER_W-1:0] DEF_LOCKOUT_CYCLES = 24'd16_000_000;
  localparam logic [2:0]         DEF_MAX_FAILS      = 3'd3;
  localparam logic [15:0]        DEF_AUTH_MASK      = 16'h0001;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/access_sequencer_hold_timer.sv
// Shared hold/timeout counter: counts enabled cycles since the last clear and
// flags the cycle in which the count reaches limit (a limit of 0 behaves as 1).
module hold_timer
  import access_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic [TIMER_W-1:0] limit_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic [TIMER_W:0]   count_plus1;

  assign count_plus1 = {1'b0, count_q} + {{TIMER_W{1'b0}}, 1'b1};
  assign expired_o   = (count_plus1 >= {1'b0, limit_i});

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != {TIMER_W{1'b1}})) begin
      count_d = count_plus1[TIMER_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/access_sequencer.sv
// Button-triggered access sequencer: requests a CNN inference, then grants,
// denies or locks out based on the returned class; all outputs registered.
module access_sequencer
  import access_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [TIMER_W-1:0] UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter logic [TIMER_W-1:0] DENY_CYCLES    = DEF_DENY_CYCLES,
  parameter logic [TIMER_W-1:0] LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter logic [2:0]         MAX_FAILS      = DEF_MAX_FAILS,
  parameter logic [15:0]        AUTH_MASK      = DEF_AUTH_MASK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       press_pulse,
  output logic       infer_start,
  input  logic       infer_done,
  input  logic [3:0] infer_class,
  output logic       door_unlock,
  output logic       deny_led,
  output logic       lockout,
  output logic       timeout_err,
  output logic [3:0] last_class,
  output logic [2:0] fail_cnt
);

  state_t             state_q, state_d;
  logic [2:0]         fail_q, fail_d, fail_next;
  logic [3:0]         class_q, class_d;
  logic               start_q, start_d;
  logic               door_q, door_d;
  logic               deny_q, deny_d;
  logic               lock_q, lock_d;
  logic               tmo_q, tmo_d;
  logic               tmr_clear, tmr_enable, tmr_expired;
  logic [TIMER_W-1:0] tmr_limit;

  assign fail_next  = sat_inc3(fail_q);
  assign tmr_clear  = (state_d != state_q);
  assign tmr_enable = (state_q == ST_WAIT) || (state_q == ST_GRANT) ||
                      (state_q == ST_DENY) || (state_q == ST_LOCKOUT);

  always_comb begin
    tmr_limit = TIMEOUT_CYCLES;
    unique case (state_q)
      ST_GRANT:   tmr_limit = UNLOCK_CYCLES;
      ST_DENY:    tmr_limit = DENY_CYCLES;
      ST_LOCKOUT: tmr_limit = LOCKOUT_CYCLES;
      default:    tmr_limit = TIMEOUT_CYCLES;
    endcase
  end

  hold_timer u_hold_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .limit_i   (tmr_limit),
    .expired_o (tmr_expired)
  );

  // infer_done outranks timer expiry in WAIT, so a late answer still counts.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    class_d = class_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press_pulse) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (infer_done) begin
          class_d = infer_class;
          if (AUTH_MASK[infer_class]) begin
            state_d = ST_GRANT;
            fail_d  = 3'd0;
          end else begin
            fail_d  = fail_next;
            state_d = (fail_next == MAX_FAILS) ? ST_LOCKOUT : ST_DENY;
          end
        end else if (tmr_expired) begin
          tmo_d   = 1'b1;
          fail_d  = fail_next;
          state_d = (fail_next == MAX_FAILS) ? ST_LOCKOUT : ST_DENY;
        end
      end
      ST_GRANT, ST_DENY: begin
        if (tmr_expired) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
          fail_d  = 3'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    start_d = (state_d == ST_START);
    door_d  = (state_d == ST_GRANT);
    deny_d  = (state_d == ST_DENY);
    lock_d  = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fail_q  <= 3'd0;
      class_q <= 4'd0;
      start_q <= 1'b0;
      door_q  <= 1'b0;
      deny_q  <= 1'b0;
      lock_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      class_q <= class_d;
      start_q <= start_d;
      door_q  <= door_d;
      deny_q  <= deny_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
    end
  end

  assign infer_start = start_q;
  assign door_unlock = door_q;
  assign deny_led    = deny_q;
  assign lockout     = lock_q;
  assign timeout_err = tmo_q;
  assign last_class  = class_q;
  assign fail_cnt    = fail_q;

endmodule

// File: tb/tb_access_sequencer.sv
// Bench for access_sequencer: directed episodes followed by randomized ones,
// each judged against an episode-level outcome model.
module tb_access_sequencer;

  localparam int          TMO   = 20;
  localparam int          UNL   = 10;
  localparam int          DNY   = 5;
  localparam int          LCK   = 30;
  localparam int          MAXF  = 3;
  localparam logic [15:0] AUTH  = 16'h0003;
  localparam int          WIN   = 56;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       press_pulse = 1'b0;
  logic       infer_start;
  logic       infer_done = 1'b0;
  logic [3:0] infer_class = 4'd0;
  logic       door_unlock, deny_led, lockout, timeout_err;
  logic [3:0] last_class;
  logic [2:0] fail_cnt;

  int n_vec = 0;
  int n_err = 0;
  int m_fail = 0;
  logic [3:0] m_last = 4'd0;

  access_sequencer #(
    .TIMEOUT_CYCLES (24'(TMO)),
    .UNLOCK_CYCLES  (24'(UNL)),
    .DENY_CYCLES    (24'(DNY)),
    .LOCKOUT_CYCLES (24'(LCK)),
    .MAX_FAILS      (3'(MAXF)),
    .AUTH_MASK      (AUTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .press_pulse (press_pulse),
    .infer_start (infer_start),
    .infer_done  (infer_done),
    .infer_class (infer_class),
    .door_unlock (door_unlock),
    .deny_led    (deny_led),
    .lockout     (lockout),
    .timeout_err (timeout_err),
    .last_class  (last_class),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {19'd0, infer_start, door_unlock, deny_led, lockout, timeout_err, last_class, fail_cnt};
  endfunction

  // One press-to-idle episode; k is the WAIT cycle of the answer, k<0 means no answer.
  task automatic run_episode(input int k, input logic [3:0] cls, input bit strays);
    int kind, len, o_start, fail_at_o;
    bit exp_to;
    int st_n = 0, st_f = -1, to_n = 0, to_f = -1;
    int dr_n = 0, dr_f = -1, dn_n = 0, dn_f = -1, lk_n = 0, lk_f = -1;
    int overlap = 0;
    logic [2:0] fc_seen = 3'bxxx;

    exp_to  = (k < 0);
    o_start = exp_to ? 2 + TMO : 3 + k;
    if (!exp_to) m_last = cls;
    if (!exp_to && AUTH[cls]) begin
      kind = 0; len = UNL; m_fail = 0;
    end else begin
      m_fail = (m_fail >= 7) ? 7 : m_fail + 1;
      if (m_fail == MAXF) begin kind = 2; len = LCK; end
      else begin kind = 1; len = DNY; end
    end
    fail_at_o = m_fail;
    if (kind == 2) m_fail = 0;

    press_pulse = 1'b1;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      press_pulse = 1'b0;
      infer_done  = 1'b0;
      infer_class = 4'($urandom_range(0, 15));
      if (infer_start) begin st_n++; if (st_f < 0) st_f = c; end
      if (timeout_err) begin to_n++; if (to_f < 0) to_f = c; end
      if (door_unlock) begin dr_n++; if (dr_f < 0) dr_f = c; end
      if (deny_led)    begin dn_n++; if (dn_f < 0) dn_f = c; end
      if (lockout)     begin lk_n++; if (lk_f < 0) lk_f = c; end
      if ((int'(door_unlock) + int'(deny_led) + int'(lockout)) > 1) overlap++;
      if (c == o_start) fc_seen = fail_cnt;
      if (k >= 0 && c == 2 + k) begin
        infer_done  = 1'b1;
        infer_class = cls;
      end else if (strays && (door_unlock || deny_led || lockout) && $urandom_range(0, 3) == 0) begin
        press_pulse = 1'b1;
        infer_done  = 1'($urandom_range(0, 1));
      end
    end

    check("start_cycles", 32'(st_n), 32'd1);
    check("start_first", 32'(st_f), 32'd1);
    check("timeout_cycles", 32'(to_n), exp_to ? 32'd1 : 32'd0);
    if (exp_to) check("timeout_first", 32'(to_f), 32'(2 + TMO));
    check("unlock_cycles", 32'(dr_n), (kind == 0) ? 32'(len) : 32'd0);
    check("deny_cycles", 32'(dn_n), (kind == 1) ? 32'(len) : 32'd0);
    check("lockout_cycles", 32'(lk_n), (kind == 2) ? 32'(len) : 32'd0);
    if (kind == 0) check("unlock_first", 32'(dr_f), 32'(o_start));
    if (kind == 1) check("deny_first", 32'(dn_f), 32'(o_start));
    if (kind == 2) check("lockout_first", 32'(lk_f), 32'(o_start));
    check("indicator_overlap", 32'(overlap), 32'd0);
    check("fail_cnt_at_outcome", 32'(fc_seen), 32'(fail_at_o));
    check("fail_cnt_end", 32'(fail_cnt), 32'(m_fail));
    check("last_class_end", 32'(last_class), 32'(m_last));
  endtask

  initial begin
    int r, k;
    logic [3:0] cls;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;

    // Press on the very first edge after reset release, authorized class 1.
    run_episode(4, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) run_episode(3, 4'd5, 1'b0);
    run_episode(-1, 4'd0, 1'b1);
    run_episode(TMO - 1, 4'd0, 1'b1);

    // Reset in the third GRANT cycle must relock the door without waiting for a clock.
    press_pulse = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      press_pulse = 1'b0;
      infer_done  = (c == 4);
      infer_class = 4'd1;
    end
    check("grant_before_reset", 32'(door_unlock), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("held_reset_outputs", all_outs(), 32'd0);
    m_fail = 0;
    m_last = 4'd0;
    rst_n  = 1'b1;
    run_episode(6, 4'd9, 1'b0);
    run_episode(2, 4'd0, 1'b0);

    for (int e = 0; e < 40; e++) begin
      r = int'($urandom_range(0, 9));
      k = (r == 9) ? TMO - 1 : int'($urandom_range(0, TMO - 1));
      cls = (r < 5) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      if (r < 2) k = -1;
      run_episode(k, cls, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/access_sequencer.md
ACCESS_SEQUENCER -- requirements
Module: access_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd50000000; WAIT cycles allowed for a result before timeout.
REQ-002 SHALL have parameter UNLOCK_CYCLES, default 24'd10000000; door_unlock hold time.
REQ-003 SHALL have parameter DENY_CYCLES, default 24'd5000000; deny_led hold time.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 24'd16000000; lockout hold time.
REQ-005 SHALL have parameter MAX_FAILS, default 3; consecutive failures that trigger lockout (range 1..7).
REQ-006 SHALL have parameter AUTH_MASK, default 16'h0001; bit i set means class i is authorized.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 press_pulse  in  1  one-cycle debounced button pulse.
REQ-010 infer_start  out  1  one-cycle request to the CNN inference engine.
REQ-011 infer_done  in  1  one-cycle result-valid strobe from the engine.
REQ-012 infer_class  in  4  predicted class, valid only with infer_done.
REQ-013 door_unlock  out  1  door actuator enable.
REQ-014 deny_led  out  1  access-denied indicator.
REQ-015 lockout  out  1  lockout indicator.
REQ-016 timeout_err  out  1  one-cycle pulse when WAIT times out.
REQ-017 last_class  out  4  class latched at the most recent accepted infer_done.
REQ-018 fail_cnt  out  3  current consecutive-failure count.

Function
REQ-019 SHALL implement FSM states IDLE, START, WAIT, GRANT, DENY, LOCKOUT; all outputs registered.
REQ-020 IDLE: press_pulse=1 -> START; press_pulse in any other state SHALL be ignored, not queued.
REQ-021 START: infer_start=1 for exactly one cycle, then WAIT unconditionally.
REQ-022 WAIT: timer starts at 0 on entry; infer_done=1 with AUTH_MASK[infer_class]=1 -> GRANT, fail_cnt cleared.
REQ-023 WAIT: infer_done=1 with AUTH_MASK[infer_class]=0 -> failure.
REQ-024 WAIT: TIMEOUT_CYCLES cycles elapse without infer_done -> timeout_err pulse for one cycle, counted as failure.
REQ-025 If infer_done and timeout occur in the same cycle, infer_done SHALL win; timeout_err stays 0.
REQ-026 On a failure, fail_cnt increments (saturating at 7); if the new value equals MAX_FAILS -> LOCKOUT, else -> DENY.
REQ-027 last_class SHALL update only on an infer_done accepted in WAIT; infer_done in any other state SHALL be ignored.
REQ-028 GRANT: door_unlock=1 for exactly UNLOCK_CYCLES cycles, beginning the cycle after infer_done is sampled, then IDLE.
REQ-029 DENY: deny_led=1 for exactly DENY_CYCLES cycles, then IDLE.
REQ-030 LOCKOUT: lockout=1 for exactly LOCKOUT_CYCLES cycles; fail_cnt cleared on exit to IDLE.
REQ-031 One 24-bit timer SHALL be shared by WAIT/GRANT/DENY/LOCKOUT, cleared on every state change; at most one of door_unlock/deny_led/lockout high at a time.

Reset
REQ-032 rst_n=0 SHALL force IDLE, timer=0, fail_cnt=0, last_class=0, and all 1-bit outputs to 0 immediately, including mid-GRANT (door relocks).
REQ-033 First press_pulse SHALL be accepted on the first clk edge after rst_n deasserts.

Structure
REQ-034 A shared package access_pkg SHALL hold the state encoding and the default timing constants.
REQ-035 One sub-module, hold_timer (clear, enable, 24-bit limit in; expired out), is natural; FSM stays in access_sequencer.

Verification (TIMEOUT=20, UNLOCK=10, DENY=5, LOCKOUT=30, MAX_FAILS=3, AUTH_MASK=16'h0003)
REQ-036 press, done at WAIT cycle 4 with class 1 -> infer_start one cycle, door_unlock high 10 cycles, last_class=1, fail_cnt=0.
REQ-037 three presses each answered with class 5 -> deny_led 5 cycles twice (fail_cnt 1,2), third gives lockout 30 cycles then fail_cnt=0.
REQ-038 press, no done -> timeout_err one cycle 20 cycles after WAIT entry, deny_led 5 cycles, fail_cnt=1.
REQ-039 done (class 0) in the same cycle the timeout expires -> GRANT, timeout_err=0; stray done and press_pulse during GRANT ignored.
REQ-040 rst_n low for 1 cycle at GRANT cycle 3 -> door_unlock drops asynchronously, all outputs 0, next press runs a clean sequence.
